packet_tx: RTL and testbench
============================

# packet_tx

Parametrised, handshaked successor to the fixed 54-bit packetiser. It accepts one INPUT_WIDTH-bit word per frame over a valid/ready handshake and serialises it onto an 8-bit bus as a framed packet: start bit, parity bit, zero pad, big-endian data, then one all-zero stop byte. It honours downstream backpressure and supports back-to-back frames with no idle cycle. It sits between a sample/record producer and the 8-bit bus interface (e.g. FIFO or FT245-style writer).

## Interface
- INPUT_WIDTH, 54: payload width in bits; legal range ≥ 1.
- Derived (localparam), not overridable: DATA_BYTES = ceil((INPUT_WIDTH+2)/8).
- Derived: PAD = 8*DATA_BYTES - (INPUT_WIDTH+2).
- Derived: FRAME_BYTES = DATA_BYTES + 1.
- Derived: CTR_WIDTH = max(1, $clog2(FRAME_BYTES)).
- clk  input  1  single clock for the block; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- di  input  INPUT_WIDTH  payload word; sampled when di_valid & di_ready.
- di_valid  input  1  producer has a word on di.
- di_ready  output  1  block can accept a word this cycle.
- data_o  output  8  current frame byte.
- data_valid  output  1  data_o holds a valid byte.
- data_ready  input  1  consumer accepts data_o this cycle.
- data_last  output  1  high with the stop byte (last byte of frame).

## Operation
- Frame bit string, MSB first: {1'b1, par, PAD'b0, di}, followed by stop byte 8'h00. For INPUT_WIDTH=54 this gives PAD=0 and FRAME_BYTES=8.
- par is defined under Configuration.
- Bytes are transferred on data_valid & data_ready. The transferred byte is data_o, from the top byte of the frame shift register downward.
- FSM states:
  - IDLE: data_valid=0; di_ready=1 (while rst is low).
  - SEND: data_valid=1; a byte counter ctr runs 0..FRAME_BYTES-1.
- IDLE → SEND on di_valid & di_ready. On that edge, load the frame shift register and set ctr=0.
- In SEND, each output handshake shifts the register left by 8 bits and increments ctr. The stop byte comes from zero-fill.
- data_last = (state==SEND) & (ctr==FRAME_BYTES-1).
- On a handshake at data_last:
  - if di_valid is high, reload the frame and stay in SEND (back-to-back, no gap);
  - otherwise go to IDLE.
- di_ready = ~rst & ((state==IDLE) | (data_last & data_ready)). This is combinational from data_ready; it is the only combinational input→output path.
- While data_valid & ~data_ready, data_o, data_last and the internal state are held stable (AXI-style stability rule).
- di is captured at acceptance. Later changes on di do not affect an in-flight frame.
- di_valid while di_ready=0 is ignored; the producer must hold it.

## Timing
- Reset (rst high, asynchronous):
  - state=IDLE, ctr=0, shift register=0;
  - data_o=8'h00, data_valid=0, data_last=0, di_ready=0.
  - di_ready rises in the first cycle with rst low.
- Latency: a word accepted at edge N gives the header byte on data_o with data_valid=1 after edge N, i.e. in cycle N+1.
- Throughput: with data_ready held high and di_valid held high, one byte per cycle; a frame completes every FRAME_BYTES cycles.
- Reset asserted mid-frame aborts the frame immediately. No partial stop byte is emitted. The next frame after release starts with a fresh header.
- ctr never exceeds FRAME_BYTES-1; no wrap-around beyond the frame.

## Configuration
- PACKET_TX_PARITY_EN defined: par = ^di (even parity over the payload), computed at acceptance.
- Undefined: par = 1'b0, and no parity XOR tree is synthesised. Frame layout and length are unchanged.

## Test plan
- INPUT_WIDTH=54, parity on, di=54'h3F_FFFF_FFFF_FFFF, data_ready=1 -> data_o sequence BF FF FF FF FF FF FF 00; data_last only on the 8th byte; then data_valid=0.
- INPUT_WIDTH=54, parity on, di=54'h1 -> C0 00 00 00 00 00 01 00.
- INPUT_WIDTH=12, di=12'hABC:
  - parity on -> CA BC 00;
  - parity off -> 8A BC 00.
- Backpressure: toggle data_ready pseudo-randomly during a frame -> byte order identical to the no-stall case; data_o stable on every stalled cycle; di_ready=0 until the last-byte handshake.
- Back-to-back: di_valid held high with two words -> second header appears in the cycle immediately after the first stop byte, with no gap.
- Reset mid-frame: assert rst after byte 3 -> data_valid drops immediately and data_o=00. After release: di_ready=1, and a new word produces a complete correct frame.

Source files
------------

// File: rtl/packet_tx.sv
// Handshaked packetiser: one INPUT_WIDTH-bit word becomes a framed byte stream
// {1, par, pad, data} + 0x00 stop byte. Parity bit is enabled by PACKET_TX_PARITY_EN.
module packet_tx #(
  parameter int INPUT_WIDTH = 54
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_WIDTH-1:0] di,
  input  logic                   di_valid,
  output logic                   di_ready,
  output logic [7:0]             data_o,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   data_last
);

  localparam int DATA_BYTES  = (INPUT_WIDTH + 2 + 7) / 8;
  localparam int PAD         = 8 * DATA_BYTES - (INPUT_WIDTH + 2);
  localparam int FRAME_BYTES = DATA_BYTES + 1;
  localparam int CTR_WIDTH   = ($clog2(FRAME_BYTES) > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int DATA_W      = 8 * DATA_BYTES;
  localparam int SR_W        = 8 * FRAME_BYTES;

  // ctr value of the byte just before the stop byte
  localparam logic [CTR_WIDTH-1:0] PRELAST_CTR = CTR_WIDTH'(FRAME_BYTES - 2);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                state;
  logic [SR_W-1:0]       sr;
  logic [CTR_WIDTH-1:0]  ctr;
  logic                  par;
  logic [DATA_W-1:0]     frame;

`ifdef PACKET_TX_PARITY_EN
  assign par = ^di;
`else
  assign par = 1'b0;
`endif

  generate
    if (PAD > 0) begin : g_pad
      assign frame = {1'b1, par, {PAD{1'b0}}, di};
    end else begin : g_nopad
      assign frame = {1'b1, par, di};
    end
  endgenerate

  assign data_o   = sr[SR_W-1 -: 8];
  assign di_ready = ~rst & ((state == IDLE) | (data_last & data_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      ctr        <= '0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (di_valid) begin
            state      <= SEND;
            sr         <= {frame, 8'h00};
            ctr        <= '0;
            data_valid <= 1'b1;
            data_last  <= 1'b0;
          end
        end
        SEND: begin
          if (data_ready) begin
            if (data_last) begin
              // stop byte accepted: chain the next word straight in if offered
              if (di_valid) begin
                sr         <= {frame, 8'h00};
                ctr        <= '0;
                data_valid <= 1'b1;
                data_last  <= 1'b0;
              end else begin
                state      <= IDLE;
                sr         <= '0;
                ctr        <= '0;
                data_valid <= 1'b0;
                data_last  <= 1'b0;
              end
            end else begin
              sr        <= sr << 8;
              ctr       <= ctr + 1'b1;
              data_last <= (ctr == PRELAST_CTR);
            end
          end
        end
        default: begin
          state      <= IDLE;
          sr         <= '0;
          ctr        <= '0;
          data_valid <= 1'b0;
          data_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_tx.sv
// Bench for packet_tx: 54-bit and 12-bit instances checked against a byte-queue frame model.
module tb_packet_tx;

`ifdef PACKET_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [53:0] a_di = '0;
  logic        a_di_valid = 1'b0, a_di_ready, a_data_valid, a_data_ready = 1'b0, a_data_last;
  logic [7:0]  a_data_o;
  logic [11:0] b_di = '0;
  logic        b_di_valid = 1'b0, b_di_ready, b_data_valid, b_data_ready = 1'b0, b_data_last;
  logic [7:0]  b_data_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] words_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  log_q[$];

  always #5 clk = ~clk;

  packet_tx #(.INPUT_WIDTH(54)) dut_a (
    .clk(clk), .rst(rst), .di(a_di), .di_valid(a_di_valid), .di_ready(a_di_ready),
    .data_o(a_data_o), .data_valid(a_data_valid), .data_ready(a_data_ready), .data_last(a_data_last)
  );

  packet_tx #(.INPUT_WIDTH(12)) dut_b (
    .clk(clk), .rst(rst), .di(b_di), .di_valid(b_di_valid), .di_ready(b_di_ready),
    .data_o(b_data_o), .data_valid(b_data_valid), .data_ready(b_data_ready), .data_last(b_data_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame as bytes: top bit 1, then parity, zero pad, payload, then a zero stop byte.
  task automatic push_frame(input logic [63:0] w, input int width);
    int          db;
    logic [63:0] val;
    logic        p;
    db  = (width + 2 + 7) / 8;
    val = w & ((64'd1 << width) - 64'd1);
    p   = PAR_EN ? ^val : 1'b0;
    val = val | (64'(p) << (8 * db - 2)) | (64'd1 << (8 * db - 1));
    for (int i = 0; i < db; i++) exp_q.push_back(8'((val >> (8 * (db - 1 - i))) & 64'hFF));
    exp_q.push_back(8'h00);
  endtask

  task automatic run_frames(input bit sel, input int stall_pct, input int max_cycles);
    int          cyc;
    int          rem;
    bit          rdy, vld;
    logic [63:0] w;
    logic [7:0]  o_data;
    logic        o_valid, o_last, o_dir;
    cyc = 0;
    while ((words_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
      @(negedge clk);
      rdy = ($urandom_range(99) >= stall_pct);
      vld = (words_q.size() > 0);
      w   = vld ? words_q[0] : {$urandom, $urandom};
      if (sel) begin
        b_di = w[11:0]; b_di_valid = vld; b_data_ready = rdy;
      end else begin
        a_di = w[53:0]; a_di_valid = vld; a_data_ready = rdy;
      end
      #1;
      o_data  = sel ? b_data_o     : a_data_o;
      o_valid = sel ? b_data_valid : a_data_valid;
      o_last  = sel ? b_data_last  : a_data_last;
      o_dir   = sel ? b_di_ready   : a_di_ready;
      rem = exp_q.size();
      check("data_valid", 64'(o_valid), 64'(rem > 0));
      check("data_last", 64'(o_last), 64'(rem == 1));
      check("di_ready", 64'(o_dir), 64'(rem == 0 || (rem == 1 && rdy)));
      if (rem > 0) check("data_o", 64'(o_data), 64'(exp_q[0]));
      if (o_valid && rdy) begin
        log_q.push_back(o_data);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (vld && o_dir) begin
        push_frame(w, sel ? 12 : 54);
        void'(words_q.pop_front());
      end
      cyc++;
    end
    check("frames_done", 64'(words_q.size() + exp_q.size()), 64'd0);
    words_q.delete();
    exp_q.delete();
    @(negedge clk);
    a_di_valid = 1'b0; b_di_valid = 1'b0; a_data_ready = 1'b1; b_data_ready = 1'b1;
    #1;
    check("idle_after", 64'(sel ? b_data_valid : a_data_valid), 64'd0);
  endtask

  task automatic check_log(input string tag, input int n, input logic [63:0] exp);
    logic [63:0] got;
    got = '0;
    foreach (log_q[i]) got = {got[55:0], log_q[i]};
    check({tag, "_len"}, 64'(log_q.size()), 64'(n));
    check(tag, got, exp);
    log_q.delete();
  endtask

  initial begin
    #2;
    check("rst_a_ready", 64'(a_di_ready), 64'd0);
    check("rst_a_valid", 64'(a_data_valid), 64'd0);
    check("rst_a_data", 64'(a_data_o), 64'd0);
    check("rst_a_last", 64'(a_data_last), 64'd0);
    check("rst_b_ready", 64'(b_di_ready), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(a_di_ready), 64'd1);
    check("post_rst_valid", 64'(a_data_valid), 64'd0);

    // Directed frames without stalls
    words_q.push_back(64'h3F_FFFF_FFFF_FFFF);
    run_frames(1'b0, 0, 50);
    check_log("ones54", 8, 64'hBFFF_FFFF_FFFF_FF00);

    words_q.push_back(64'h1);
    run_frames(1'b0, 0, 50);
    check_log("one54", 8, PAR_EN ? 64'hC000_0000_0000_0100 : 64'h8000_0000_0000_0100);

    words_q.push_back(64'hABC);
    run_frames(1'b1, 0, 50);
    check_log("abc12", 3, PAR_EN ? 64'hCABC00 : 64'h8ABC00);

    // Back-to-back with di_valid held, then random words under backpressure
    words_q.push_back({$urandom, $urandom});
    words_q.push_back({$urandom, $urandom});
    run_frames(1'b0, 0, 50);
    check("b2b_len", 64'(log_q.size()), 64'd16);
    log_q.delete();

    for (int i = 0; i < 6; i++) words_q.push_back({$urandom, $urandom});
    run_frames(1'b0, 40, 400);
    for (int i = 0; i < 6; i++) words_q.push_back({$urandom, $urandom});
    run_frames(1'b1, 40, 200);
    log_q.delete();

    // Reset in the middle of a frame, after three bytes have gone out
    @(negedge clk);
    a_di = 54'h12_3456_789A_BCDE; a_di_valid = 1'b1; a_data_ready = 1'b1;
    @(posedge clk);
    #1 a_di_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_valid", 64'(a_data_valid), 64'd0);
    check("abort_data", 64'(a_data_o), 64'd0);
    check("abort_last", 64'(a_data_last), 64'd0);
    check("abort_ready", 64'(a_di_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready", 64'(a_di_ready), 64'd1);
    check("rel_valid", 64'(a_data_valid), 64'd0);
    words_q.push_back(64'h3F_FFFF_FFFF_FFFF);
    run_frames(1'b0, 30, 100);
    check_log("after_abort", 8, 64'hBFFF_FFFF_FFFF_FF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
